pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Frame-rate game controller for the two-player Pong display. It owns the ball position, the ball velocity, both paddle positions and both scores, and advances them once per video frame. It sequences the match through idle, serve, play, point and game-over phases. Its position outputs drive the pixel generator's `ball_x`, `ball_y`, `paddle1_y` and `paddle2_y` directly.

## Interface

- Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- `PADDLE_SPEED`, default 4: paddle step in pixels per frame.
- `BALL_SPEED`, default 2: ball step per frame, same magnitude on each axis.
- `WIN_SCORE`, default 9: score that ends the match (range 1..15).
- `SERVE_DELAY`, default 60: frames held in SERVE (range 1..255).

Ports:
- `clk`, input, 1: system clock (pixel clock domain).
- `rst_n`, input, 1: asynchronous active-low reset.
- `frame_tick`, input, 1: one-cycle pulse per frame, issued during vertical blank.
- `btn_start`, input, 1: start or restart; level, already debounced and synchronised.
- `p1_up`, `p1_dn`, `p2_up`, `p2_dn`, input, 1 each: paddle buttons; level, debounced.
- `ball_x`, `ball_y`, output, 10 each: top-left corner of the 8×8 ball.
- `paddle1_y`, `paddle2_y`, output, 10 each: top row of each 73-pixel paddle.
- `score1`, `score2`, output, 4 each: player scores.
- `playing`, output, 1: high in the SERVE, PLAY and POINT states.
- `game_over`, output, 1: high in the OVER state.

## Operation

Geometry:
- Playfield is 640×480.
- Left paddle spans x = 32..40; right paddle spans x = 600..608.
- Paddle occupies rows `paddle_y`..`paddle_y+72`.
- Ball x limits are 41..592; ball y limits are 0..472; paddle y limits are 0..407.
- Ball centre position is (316, 236).

State machine:
- IDLE: ball at centre, scores hold. If `btn_start` = 1 → SERVE, with scores cleared.
- SERVE: ball held at centre. The frame counter counts ticks; after `SERVE_DELAY` ticks → PLAY.
- PLAY: on each tick, move the ball by (vx, vy), where each component is ±`BALL_SPEED`.
  - Top: if vy < 0 and `ball_y` < `BALL_SPEED`, set `ball_y` = 0 and make vy positive.
  - Bottom: if vy > 0 and `ball_y` + `BALL_SPEED` > 472, set `ball_y` = 472 and make vy negative.
  - Left: if vx < 0 and `ball_x` < 41 + `BALL_SPEED`, check overlap with the left paddle, i.e. `ball_y`+7 ≥ `paddle1_y` and `ball_y` ≤ `paddle1_y`+72.
    - Overlap: set `ball_x` = 41 and make vx positive.
    - No overlap: player 2 scores → POINT.
  - Right: the same test against 592 and `paddle2_y`. On a hit, set `ball_x` = 592 and make vx negative; on a miss, player 1 scores.
  - The x and y checks are evaluated independently in the same tick, so a corner hit reflects both axes.
- POINT: lasts exactly one clock.
  - Increment the scorer's score.
  - If the new score equals `WIN_SCORE` → OVER; otherwise → SERVE.
  - Load the next serve velocity: vx points toward the player who conceded, and vy is the previous serve's vy negated.
- OVER: all positions freeze. If `btn_start` = 1 → SERVE, with scores cleared and the ball at centre.

Paddles:
- Paddles update on ticks in IDLE, SERVE and PLAY.
- Up only: `y` decreases by `PADDLE_SPEED`, saturating at 0.
- Down only: `y` increases by `PADDLE_SPEED`, saturating at 407.
- Both buttons or neither: hold.
- Paddles are frozen in OVER.

Arithmetic and storage:
- Do bound checks with 11-bit unsigned intermediates, so there is no wrap near 0 or 1023.
- Store velocity as sign bits only.

## Timing

- Every output is a register; an update is visible on the clock edge after the `frame_tick` cycle (1-cycle latency).
- Reset values:
  - `ball_x` = 316, `ball_y` = 236.
  - `paddle1_y` = `paddle2_y` = 204.
  - Scores = 0.
  - vx = +, vy = +.
  - State IDLE, `playing` = 0, `game_over` = 0.
- `btn_start` is honoured on any cycle; a tick is not required.
- If `btn_start` and `frame_tick` are both high in IDLE or OVER, the state transition wins and the ball does not move. In IDLE the paddles still step that tick.
- A `frame_tick` arriving during POINT is ignored for ball motion; paddles still step.
- `rst_n` low at any time forces all reset values asynchronously, including mid-play.

## Structure

- Shared package `pong_pkg` holds:
  - geometry constants: `H_RES`, `V_RES`, `BALL_SIZE`, `PADDLE_H`, `WALL_L`, `WALL_R`, and the paddle x edges, also consumed by the pixel generator;
  - the state encoding: IDLE, SERVE, PLAY, POINT, OVER.
- Sub-module `paddle_mover` is instantiated twice. Inputs: `clk`, `rst_n`, `tick`, `up`, `dn`, `freeze`. Output: saturating `y`.

## Test plan

- Reset, then 5 ticks with no buttons → positions stay at (316, 236) and paddles at 204; `playing` = 0.
- `p1_up` held for 60 ticks from 204 → `paddle1_y` decreases by 4 per tick and saturates at 0 on tick 51. `p1_up` and `p1_dn` both held → paddle holds.
- Start, then wait 60 ticks → PLAY. The ball moves to (318, 238) on the first PLAY tick. With the ball at y = 471 and vy = + → `ball_y` = 472 and vy becomes −.
- Force the ball to x = 42, vx = −, with `paddle1_y` = 200 and `ball_y` = 230 → `ball_x` = 41 and vx becomes +. With `ball_y` = 100 instead → `score2` = 1, SERVE entered, ball recentred.
- Right-side misses with `score1` = 8 → `score1` = 9, `game_over` = 1 one clock later, positions frozen. Then `btn_start` → scores 0, SERVE.
- Pulse `rst_n` low mid-PLAY with scores 3:5 → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pong_pkg
// Description : Shared Pong geometry and match state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    // Geometry, shared with the pixel generator
    localparam logic [10:0] H_RES        = 11'd640;
    localparam logic [10:0] V_RES        = 11'd480;
    localparam logic [10:0] BALL_SIZE    = 11'd8;
    localparam logic [10:0] PADDLE_H     = 11'd73;
    localparam logic [10:0] WALL_L       = 11'd41;
    localparam logic [10:0] WALL_R       = 11'd592;
    localparam logic [10:0] PADDLE1_X_L  = 11'd32;
    localparam logic [10:0] PADDLE1_X_R  = 11'd40;
    localparam logic [10:0] PADDLE2_X_L  = 11'd600;
    localparam logic [10:0] PADDLE2_X_R  = 11'd608;
    localparam logic [10:0] BALL_Y_MAX   = 11'd472;
    localparam logic [10:0] PADDLE_Y_MAX = 11'd407;
    localparam logic [10:0] BALL_X_CTR   = 11'd316;
    localparam logic [10:0] BALL_Y_CTR   = 11'd236;
    localparam logic [10:0] PADDLE_Y_RST = 11'd204;

    // Match state encoding
    localparam int         STATE_W  = 3;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/paddle_mover.sv
`default_nettype none
// ============================================================================
// Module      : paddle_mover
// Description : One paddle's vertical position, saturating at 0 and 407.
// Revision    : 1.0 - initial release
// ============================================================================
module paddle_mover
    import pong_pkg::*;
#(
    parameter int SPEED = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       up,
    input  logic       dn,
    input  logic       freeze,
    output logic [9:0] y
);

    localparam logic [10:0] c_step = 11'(SPEED);

    logic [9:0]  r_y;
    logic [9:0]  w_y_nxt;
    logic [10:0] w_y_ext;
    logic [10:0] w_y_inc;
    logic [10:0] w_y_dec;

    assign w_y_ext = {1'b0, r_y};
    assign w_y_inc = w_y_ext + c_step;
    assign w_y_dec = w_y_ext - c_step;

    // Borrow out of the 11-bit subtract means the step would cross row 0
    always_comb begin
        w_y_nxt = r_y;
        if (tick && !freeze && (up != dn)) begin
            if (up) begin
                w_y_nxt = w_y_dec[10] ? 10'd0 : w_y_dec[9:0];
            end else begin
                w_y_nxt = (w_y_inc > PADDLE_Y_MAX) ? PADDLE_Y_MAX[9:0] : w_y_inc[9:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y <= PADDLE_Y_RST[9:0];
        end else begin
            r_y <= w_y_nxt;
        end
    end

    assign y = r_y;

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Frame-rate Pong match controller: ball, paddles, scores.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SPEED   = 2,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_DELAY  = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle1_y,
    output logic [9:0] paddle2_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       playing,
    output logic       game_over
);

    localparam logic [10:0] c_ball_step   = 11'(BALL_SPEED);
    localparam logic [9:0]  c_ball_step10 = 10'(BALL_SPEED);
    localparam logic [10:0] c_left_lim    = WALL_L + c_ball_step;
    localparam logic [7:0]  c_serve_last  = 8'(SERVE_DELAY - 1);
    localparam logic [3:0]  c_win         = 4'(WIN_SCORE);

    logic [STATE_W-1:0] r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [9:0]  r_ball_x, w_ball_x_nxt;
    logic [9:0]  r_ball_y, w_ball_y_nxt;
    logic        r_vx_neg, w_vx_neg_nxt;
    logic        r_vy_neg, w_vy_neg_nxt;
    logic        r_serve_vy_neg, w_serve_vy_neg_nxt;
    logic [3:0]  r_score1, w_score1_nxt;
    logic [3:0]  r_score2, w_score2_nxt;
    logic        r_scorer_p2, w_scorer_p2_nxt;
    logic        r_playing, r_game_over;

    logic [9:0]  w_pad1_y, w_pad2_y;
    logic [10:0] w_bx_ext, w_by_ext, w_bx_inc, w_by_inc, w_by_dec, w_ball_bot;
    logic [3:0]  w_new_score;
    logic        w_hit1, w_hit2, w_freeze, w_recentre;

    assign w_bx_ext   = {1'b0, r_ball_x};
    assign w_by_ext   = {1'b0, r_ball_y};
    assign w_bx_inc   = w_bx_ext + c_ball_step;
    assign w_by_inc   = w_by_ext + c_ball_step;
    assign w_by_dec   = w_by_ext - c_ball_step;
    assign w_ball_bot = w_by_ext + (BALL_SIZE - 11'd1);

    assign w_hit1 = (w_ball_bot >= {1'b0, w_pad1_y}) &&
                    (w_by_ext <= ({1'b0, w_pad1_y} + (PADDLE_H - 11'd1)));
    assign w_hit2 = (w_ball_bot >= {1'b0, w_pad2_y}) &&
                    (w_by_ext <= ({1'b0, w_pad2_y} + (PADDLE_H - 11'd1)));

    assign w_new_score = (r_scorer_p2 ? r_score2 : r_score1) + 4'd1;
    assign w_freeze    = (r_state == ST_OVER);

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_ball_x_nxt       = r_ball_x;
        w_ball_y_nxt       = r_ball_y;
        w_vx_neg_nxt       = r_vx_neg;
        w_vy_neg_nxt       = r_vy_neg;
        w_serve_vy_neg_nxt = r_serve_vy_neg;
        w_score1_nxt       = r_score1;
        w_score2_nxt       = r_score2;
        w_scorer_p2_nxt    = r_scorer_p2;
        w_recentre         = 1'b0;

        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (btn_start) begin
                    w_state_nxt  = ST_SERVE;
                    w_cnt_nxt    = 8'd0;
                    w_score1_nxt = 4'd0;
                    w_score2_nxt = 4'd0;
                    w_recentre   = 1'b1;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (r_cnt == c_serve_last) begin
                        w_state_nxt = ST_PLAY;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (r_vy_neg) begin
                        if (w_by_dec[10]) begin
                            w_ball_y_nxt = 10'd0;
                            w_vy_neg_nxt = 1'b0;
                        end else begin
                            w_ball_y_nxt = w_by_dec[9:0];
                        end
                    end else if (w_by_inc > BALL_Y_MAX) begin
                        w_ball_y_nxt = BALL_Y_MAX[9:0];
                        w_vy_neg_nxt = 1'b1;
                    end else begin
                        w_ball_y_nxt = w_by_inc[9:0];
                    end

                    // On a miss the ball x is left where it was for the POINT cycle
                    if (r_vx_neg) begin
                        if (w_bx_ext < c_left_lim) begin
                            if (w_hit1) begin
                                w_ball_x_nxt = WALL_L[9:0];
                                w_vx_neg_nxt = 1'b0;
                            end else begin
                                w_state_nxt     = ST_POINT;
                                w_scorer_p2_nxt = 1'b1;
                            end
                        end else begin
                            w_ball_x_nxt = r_ball_x - c_ball_step10;
                        end
                    end else if (w_bx_inc > WALL_R) begin
                        if (w_hit2) begin
                            w_ball_x_nxt = WALL_R[9:0];
                            w_vx_neg_nxt = 1'b1;
                        end else begin
                            w_state_nxt     = ST_POINT;
                            w_scorer_p2_nxt = 1'b0;
                        end
                    end else begin
                        w_ball_x_nxt = w_bx_inc[9:0];
                    end
                end
            end
            ST_POINT: begin
                // Serve toward the conceder, alternating the vertical direction
                w_vx_neg_nxt       = r_scorer_p2;
                w_serve_vy_neg_nxt = ~r_serve_vy_neg;
                w_vy_neg_nxt       = ~r_serve_vy_neg;
                if (r_scorer_p2) begin
                    w_score2_nxt = w_new_score;
                end else begin
                    w_score1_nxt = w_new_score;
                end
                if (w_new_score == c_win) begin
                    w_state_nxt = ST_OVER;
                end else begin
                    w_state_nxt = ST_SERVE;
                    w_cnt_nxt   = 8'd0;
                    w_recentre  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_recentre) begin
            w_ball_x_nxt = BALL_X_CTR[9:0];
            w_ball_y_nxt = BALL_Y_CTR[9:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 8'd0;
            r_ball_x       <= BALL_X_CTR[9:0];
            r_ball_y       <= BALL_Y_CTR[9:0];
            r_vx_neg       <= 1'b0;
            r_vy_neg       <= 1'b0;
            r_serve_vy_neg <= 1'b0;
            r_score1       <= 4'd0;
            r_score2       <= 4'd0;
            r_scorer_p2    <= 1'b0;
            r_playing      <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_ball_x       <= w_ball_x_nxt;
            r_ball_y       <= w_ball_y_nxt;
            r_vx_neg       <= w_vx_neg_nxt;
            r_vy_neg       <= w_vy_neg_nxt;
            r_serve_vy_neg <= w_serve_vy_neg_nxt;
            r_score1       <= w_score1_nxt;
            r_score2       <= w_score2_nxt;
            r_scorer_p2    <= w_scorer_p2_nxt;
            r_playing      <= (w_state_nxt == ST_SERVE) || (w_state_nxt == ST_PLAY) ||
                              (w_state_nxt == ST_POINT);
            r_game_over    <= (w_state_nxt == ST_OVER);
        end
    end

    paddle_mover #(.SPEED(PADDLE_SPEED)) u_paddle1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (frame_tick),
        .up     (p1_up),
        .dn     (p1_dn),
        .freeze (w_freeze),
        .y      (w_pad1_y)
    );

    paddle_mover #(.SPEED(PADDLE_SPEED)) u_paddle2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (frame_tick),
        .up     (p2_up),
        .dn     (p2_dn),
        .freeze (w_freeze),
        .y      (w_pad2_y)
    );

    assign ball_x    = r_ball_x;
    assign ball_y    = r_ball_y;
    assign paddle1_y = w_pad1_y;
    assign paddle2_y = w_pad2_y;
    assign score1    = r_score1;
    assign score2    = r_score2;
    assign playing   = r_playing;
    assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_game_ctrl
// Description : Randomised scoreboard bench for pong_game_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    localparam int PS  = 4;
    localparam int BS  = 2;
    localparam int WIN = 9;
    localparam int SD  = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_start = 1'b0;
    logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
    logic [9:0] ball_x, ball_y, paddle1_y, paddle2_y;
    logic [3:0] score1, score2;
    logic       playing, game_over;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_start  (btn_start),
        .p1_up      (p1_up),
        .p1_dn      (p1_dn),
        .p2_up      (p2_up),
        .p2_dn      (p2_dn),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .paddle1_y  (paddle1_y),
        .paddle2_y  (paddle2_y),
        .score1     (score1),
        .score2     (score2),
        .playing    (playing),
        .game_over  (game_over)
    );

    typedef struct {
        int bx; int by; int p1; int p2; int s1; int s2; bit pl; bit go;
    } snap_t;

    typedef enum {M_IDLE, M_SERVE, M_PLAY, M_POINT, M_OVER} mphase_t;

    snap_t   exp_q[$];
    snap_t   mon_e;
    int      checks = 0;
    int      failures = 0;

    // Reference model state (velocities as signed pixel steps)
    mphase_t ph;
    int      bx, by, vx, vy, svy, p1, p2, s1, s2, cnt, scorer;

    task automatic model_reset();
        ph = M_IDLE; bx = 316; by = 236; vx = BS; vy = BS; svy = BS;
        p1 = 204; p2 = 204; s1 = 0; s2 = 0; cnt = 0; scorer = 0;
    endtask

    function automatic int pad_move(input int y, input bit u, input bit d);
        if (u && !d) return (y - PS < 0) ? 0 : y - PS;
        if (d && !u) return (y + PS > 407) ? 407 : y + PS;
        return y;
    endfunction

    function automatic bit overlap(input int y, input int pad);
        return (y + 7 >= pad) && (y <= pad + 72);
    endfunction

    task automatic model_step(input bit st, input bit tk, input bit u1, input bit d1,
                              input bit u2, input bit d2);
        int np1, np2, nbx, nby;
        snap_t e;
        np1 = p1; np2 = p2; nbx = bx; nby = by;
        if (ph != M_OVER && tk) begin
            np1 = pad_move(p1, u1, d1);
            np2 = pad_move(p2, u2, d2);
        end
        case (ph)
            M_IDLE, M_OVER: if (st) begin
                ph = M_SERVE; s1 = 0; s2 = 0; cnt = 0; nbx = 316; nby = 236;
            end
            M_SERVE: if (tk) begin
                cnt++;
                if (cnt == SD) begin ph = M_PLAY; cnt = 0; end
            end
            M_PLAY: if (tk) begin
                if (vy < 0 && by < BS) begin nby = 0; vy = BS; end
                else if (vy > 0 && by + BS > 472) begin nby = 472; vy = -BS; end
                else nby = by + vy;
                if (vx < 0 && bx < 41 + BS) begin
                    if (overlap(by, p1)) begin nbx = 41; vx = BS; end
                    else begin scorer = 2; ph = M_POINT; end
                end else if (vx > 0 && bx + BS > 592) begin
                    if (overlap(by, p2)) begin nbx = 592; vx = -BS; end
                    else begin scorer = 1; ph = M_POINT; end
                end else begin
                    nbx = bx + vx;
                end
            end
            M_POINT: begin
                if (scorer == 1) s1++; else s2++;
                vx = (scorer == 1) ? BS : -BS;
                svy = -svy; vy = svy;
                if (((scorer == 1) ? s1 : s2) == WIN) ph = M_OVER;
                else begin ph = M_SERVE; cnt = 0; nbx = 316; nby = 236; end
            end
            default: ;
        endcase
        bx = nbx; by = nby; p1 = np1; p2 = np2;
        e.bx = bx; e.by = by; e.p1 = p1; e.p2 = p2; e.s1 = s1; e.s2 = s2;
        e.pl = (ph == M_SERVE) || (ph == M_PLAY) || (ph == M_POINT);
        e.go = (ph == M_OVER);
        exp_q.push_back(e);
    endtask

    task automatic step(input bit st, input bit tk, input bit u1, input bit d1,
                        input bit u2, input bit d2);
        @(negedge clk);
        btn_start = st; frame_tick = tk;
        p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
        model_step(st, tk, u1, d1, u2, d2);
    endtask

    // Tracking player: skill is the percentage of ticks spent chasing the ball
    function automatic logic [1:0] pick(input int pad, input int skill);
        int tgt;
        tgt = by - 32;
        if ($urandom_range(0, 99) < skill) begin
            if (pad > tgt + 2) return 2'b10;
            if (pad < tgt - 2) return 2'b01;
            return 2'b00;
        end
        return 2'($urandom_range(0, 3));
    endfunction

    task automatic play_tick(input int sk1, input int sk2);
        logic [1:0] b1, b2;
        bit st;
        int gap;
        b1 = pick(p1, sk1);
        b2 = pick(p2, sk2);
        st = ((ph == M_PLAY) || (ph == M_SERVE)) && ($urandom_range(0, 99) < 3);
        step(st, 1'b1, b1[1], b1[0], b2[1], b2[0]);
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) step(1'b0, 1'b0, b1[1], b1[0], b2[1], b2[0]);
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (ball_x !== 10'd316 || ball_y !== 10'd236 || paddle1_y !== 10'd204 ||
            paddle2_y !== 10'd204 || score1 !== 4'd0 || score2 !== 4'd0 ||
            playing !== 1'b0 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL %s: got bx=%0d by=%0d p1=%0d p2=%0d s1=%0d s2=%0d pl=%0b go=%0b, need 316 236 204 204 0 0 0 0",
                     tag, ball_x, ball_y, paddle1_y, paddle2_y, score1, score2, playing, game_over);
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        btn_start = 0; frame_tick = 0; p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one scoreboard entry per clock after stimulus
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                if (ball_x !== 10'(mon_e.bx) || ball_y !== 10'(mon_e.by) ||
                    paddle1_y !== 10'(mon_e.p1) || paddle2_y !== 10'(mon_e.p2) ||
                    score1 !== 4'(mon_e.s1) || score2 !== 4'(mon_e.s2) ||
                    playing !== mon_e.pl || game_over !== mon_e.go) begin
                    failures++;
                    $display("FAIL outputs @%0t: got bx=%0d by=%0d p1=%0d p2=%0d s1=%0d s2=%0d pl=%0b go=%0b, need bx=%0d by=%0d p1=%0d p2=%0d s1=%0d s2=%0d pl=%0b go=%0b",
                             $time, ball_x, ball_y, paddle1_y, paddle2_y, score1, score2,
                             playing, game_over, mon_e.bx, mon_e.by, mon_e.p1, mon_e.p2,
                             mon_e.s1, mon_e.s2, mon_e.pl, mon_e.go);
                end
            end
        end
    end

    initial begin
        int budget;
        model_reset();
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: no buttons, then paddle saturation and both-button hold
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) begin
            step(0, 1, 1, 0, 0, 1);
            step(0, 0, 1, 0, 0, 1);
        end
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 1, 1);
        for (int i = 0; i < 30; i++) step(0, 1, 0, 1, 1, 0);

        // Start together with a tick: paddles still step in IDLE
        step(1, 1, 0, 1, 1, 0);

        // Game 1: strong left player should win
        budget = 20000;
        while (ph != M_OVER && budget > 0) begin
            play_tick(85, 30);
            budget--;
        end
        checks++;
        if (ph != M_OVER) begin
            failures++;
            $display("FAIL game1_timeout: got phase %s, need OVER within tick budget", ph.name());
        end

        // OVER: everything frozen despite buttons and ticks
        for (int i = 0; i < 10; i++)
            step(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 1);

        // Game 2: even match, reset asynchronously once some points are in
        budget = 20000;
        while (!(s1 + s2 >= 3 && ph == M_PLAY) && budget > 0) begin
            play_tick(55, 55);
            budget--;
        end
        checks++;
        if (budget == 0) begin
            failures++;
            $display("FAIL game2_timeout: got s1=%0d s2=%0d, need 3 points in play", s1, s2);
        end
        for (int i = 0; i < 7; i++) play_tick(55, 55);
        async_reset();

        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 120; i++) play_tick(60, 60);
        step(0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
